// File: rtl/accum_pkg.sv
// Shared types and defaults for the accumulating adder sequencer.
package accum_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_CNT_W  = 4;
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OP,
        SETTLE,
        DONE
    } accum_state_t;

endpackage

// File: rtl/accum_datapath.sv
// Ripple-friendly adder plus accumulator register.
module accum_datapath
    import accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] total;

    assign total = {1'b0, sum} + {1'b0, operand};
    assign carry = total[WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (load) begin
            sum <= total[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/accum_sequencer.sv
// Sequences N operands through the accumulator, waiting a
// programmable settle window before each register capture.
module accum_sequencer
    import accum_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    accum_state_t         state_q;
    accum_state_t         state_d;
    logic [CNT_W-1:0]     remaining;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [WIDTH-1:0]     operand_reg;
    logic                 carry;
    logic                 accept;
    logic                 handshake;
    logic                 capture;

    assign accept    = (state_q == IDLE) && start;
    assign handshake = op_valid && op_ready;
    assign capture   = (state_q == SETTLE) && (settle_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_ops != '0) ? WAIT_OP : DONE;
                end
            end
            WAIT_OP: begin
                op_ready = 1'b1;
                busy     = 1'b1;
                if (op_valid) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) begin
                    state_d = (remaining == CNT_W'(1)) ? DONE : WAIT_OP;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand is held stable in operand_reg while the adder settles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining   <= '0;
            settle_cnt  <= '0;
            operand_reg <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                remaining <= num_ops;
                overflow  <= 1'b0;
            end else if (capture) begin
                remaining <= remaining - CNT_W'(1);
                overflow  <= overflow | carry;
            end
            if (handshake) begin
                operand_reg <= op_data;
                settle_cnt  <= SETTLE_W'(SETTLE_CYCLES - 1);
            end else if ((state_q == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
        end
    end

    accum_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .clr    (accept),
        .load   (capture),
        .operand(operand_reg),
        .sum    (sum),
        .carry  (carry)
    );

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed and randomized runs checked against an arithmetic model.
module tb_accum_sequencer;

    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;
    localparam int SETTLE = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_ops = '0;
    logic             op_valid = 1'b0;
    logic [WIDTH-1:0] op_data = '0;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    int tests = 0;
    int fails = 0;
    int ops[16];

    accum_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .num_ops (num_ops),
        .op_valid(op_valid),
        .op_data (op_data),
        .op_ready(op_ready),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum of the run; any lost carry means
    // the true total reached 2^WIDTH.
    function automatic void model(input int n, output int esum,
                                  output int eovf);
        int t = 0;
        for (int i = 0; i < n; i++) t += ops[i];
        esum = t % (1 << WIDTH);
        eovf = (t >= (1 << WIDTH)) ? 1 : 0;
    endfunction

    task automatic run(input string tag, input int n, input int stall,
                       input bit poke, input int abort_at);
        int idx = 0;
        int k = 0;
        int stalled = 0;
        int esum, eovf, exp_lat, psum, povf;
        bit got = 0;
        bit saw = 0;
        bit aborted = 0;
        model(n, esum, eovf);
        exp_lat = n * (1 + SETTLE) + 2 + ((n > 0) ? stall : 0);
        @(negedge clock);
        start = 1'b1;
        num_ops = CNT_W'(n);
        op_valid = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        num_ops = CNT_W'($urandom);
        while (!got && !aborted && k < 500) begin
            if (done) begin
                got = 1;
            end else begin
                if (op_ready) begin
                    saw = 1;
                    if (idx == 0 && stalled < stall) begin
                        op_valid = 1'b0;
                        op_data = WIDTH'($urandom);
                        stalled++;
                    end else begin
                        op_valid = 1'b1;
                        op_data = WIDTH'((idx < 16) ? ops[idx] : 0);
                        idx++;
                    end
                end else begin
                    op_valid = 1'($urandom);
                    op_data = WIDTH'($urandom);
                    if (poke && busy) start = 1'b1;
                end
                @(posedge clock);
                #1;
                k++;
                start = 1'b0;
                if (abort_at >= 0 && idx == abort_at && busy && !op_ready) begin
                    model(abort_at - 1, psum, povf);
                    check({tag, "/pre_rst_sum"}, 32'(sum), 32'(psum));
                    #2;
                    reset = 1'b1;
                    #1;
                    check({tag, "/rst_sum"}, 32'(sum), 0);
                    check({tag, "/rst_ovf"}, 32'(overflow), 0);
                    check({tag, "/rst_busy"}, 32'(busy), 0);
                    check({tag, "/rst_ready"}, 32'(op_ready), 0);
                    #3;
                    reset = 1'b0;
                    aborted = 1;
                end
            end
        end
        op_valid = 1'b0;
        if (aborted) return;
        if (!got) begin
            check({tag, "/timeout"}, 0, 1);
            return;
        end
        check({tag, "/latency"}, 32'(k + 2), 32'(exp_lat));
        check({tag, "/sum"}, 32'(sum), 32'(esum));
        check({tag, "/ovf"}, 32'(overflow), 32'(eovf));
        if (n == 0) check({tag, "/no_ready"}, 32'(saw), 0);
        @(posedge clock);
        #1;
        check({tag, "/done_pulse"}, 32'(done), 0);
        check({tag, "/idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int esum, eovf;
        repeat (3) @(posedge clock);
        #1;
        check("reset/sum", 32'(sum), 0);
        check("reset/ovf", 32'(overflow), 0);
        check("reset/busy", 32'(busy), 0);
        check("reset/ready", 32'(op_ready), 0);
        check("reset/done", 32'(done), 0);
        @(negedge clock);
        reset = 1'b0;

        ops[0] = 10; ops[1] = 20; ops[2] = 30;
        run("basic", 3, 0, 0, -1);

        ops[0] = 200; ops[1] = 100;
        run("wrap", 2, 0, 0, -1);
        repeat (5) @(posedge clock);
        #1;
        check("wrap/hold_ovf", 32'(overflow), 1);
        check("wrap/hold_sum", 32'(sum), 44);

        run("zero", 0, 0, 0, -1);

        for (int i = 0; i < 3; i++) ops[i] = $urandom_range(0, 255);
        run("stall", 3, 5, 1, -1);
        model(3, esum, eovf);
        repeat (4) @(posedge clock);
        #1;
        check("stall/no_restart", 32'(busy), 0);
        check("stall/sum_kept", 32'(sum), 32'(esum));

        ops[0] = 5; ops[1] = 7;
        run("abort", 2, 0, 0, 2);
        ops[0] = 1; ops[1] = 2;
        run("after_rst", 2, 0, 0, -1);

        ops[0] = 250; ops[1] = 10;
        run("runA", 2, 0, 0, -1);
        ops[0] = 1; ops[1] = 1;
        run("runB", 2, 0, 0, -1);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) ops[i] = $urandom_range(0, 255);
            run($sformatf("rand%0d", r), n, $urandom_range(0, 3),
                1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Control block that sequences an 8-bit accumulating adder across a run of N operands, delivered over a valid/ready stream.
- Gives the combinational adder a programmable settle window before each register capture, so it runs safely with slow ripple adders.
- Reports the final sum, a sticky overflow flag and a one-cycle done pulse.
- Sits between an operand producer (testbench or upstream FSM) and the accumulator datapath, which it owns.

Parameters:
- WIDTH, 8, operand and accumulator width in bits.
- CNT_W, 4, width of the operand-count input (max 15 operands per run).
- SETTLE_CYCLES, 3, clock cycles the adder output is allowed to settle before capture; legal range 1..15.

Ports:
- clock  input  1  single system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request a new run; sampled only in IDLE.
- num_ops  input  CNT_W  operand count for the run; latched when start is accepted.
- op_valid  input  1  operand present on op_data.
- op_data  input  WIDTH  operand value.
- op_ready  output  1  block will accept an operand this cycle.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse, run complete.
- sum  output  WIDTH  accumulator register value, continuously driven.
- overflow  output  1  sticky carry-out of any add in the current run.

Behaviour:
- Interface: one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset (async, any state, mid-operation included):
  - state goes to IDLE; acc, sum and overflow go to 0.
  - op_ready, busy and done go to 0; internal counters go to 0.
  - An operand in flight is discarded.
- States: IDLE, WAIT_OP, SETTLE, DONE.
- IDLE:
  - busy=0, op_ready=0.
  - On start=1: acc<=0, overflow<=0, remaining<=num_ops.
  - Next state is WAIT_OP if num_ops!=0, else DONE.
- WAIT_OP:
  - op_ready=1, busy=1.
  - On op_valid&op_ready: operand_reg<=op_data, settle_cnt<=SETTLE_CYCLES-1, next state SETTLE.
  - Otherwise hold; there is no timeout.
- SETTLE:
  - op_ready=0, busy=1.
  - While settle_cnt!=0, decrement settle_cnt.
  - When settle_cnt==0: {carry,acc}<=acc+operand_reg (width WIDTH+1), overflow<=overflow|carry, remaining<=remaining-1.
  - Next state is DONE if remaining==1, else WAIT_OP.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency:
  - Start acceptance to first op_ready: 1 cycle.
  - Per operand: 1 handshake cycle + SETTLE_CYCLES cycles.
  - Total for N>0 operands with no stalls: 1 + N*(1+SETTLE_CYCLES) + 1 cycles to done.
- Arithmetic: modulo 2^WIDTH. sum wraps and overflow records the lost carry. sum and overflow hold their values after DONE until the next accepted start or reset.
- Ignored inputs:
  - start is ignored in WAIT_OP, SETTLE and DONE.
  - op_valid is ignored outside WAIT_OP; the producer must hold data until op_ready.
- num_ops changes after acceptance have no effect on the current run.
- start and reset asserted together: reset wins.
- sum never glitches mid-settle: the register only loads at the capture edge.

Decomposition:
- Shared package accum_pkg holds:
  - state enum accum_state_t {IDLE, WAIT_OP, SETTLE, DONE};
  - default WIDTH/CNT_W constants;
  - SETTLE_MAX=15.
- One sub-module, accum_datapath: WIDTH-bit adder plus accumulator register with clear and load-enable inputs, returning sum and carry.
- The FSM, counters and operand register stay in accum_sequencer.

Test Plan:
- start, num_ops=3, operands 10,20,30 with op_valid always high, SETTLE_CYCLES=3 -> done pulses at cycle 14 after start, sum=60, overflow=0.
- num_ops=2, operands 200,100 -> sum=44, overflow=1, and overflow stays 1 until the next start.
- num_ops=0 -> done on the cycle after start, sum=0, op_ready never asserted.
- Producer withholds op_valid for 5 cycles in WAIT_OP; start pulsed during SETTLE -> FSM waits with op_ready=1, final sum is unchanged, the second start has no effect.
- Reset asserted asynchronously mid-SETTLE of the second operand (run 5,7) -> sum=0, overflow=0, busy=0, op_ready=0 immediately; a fresh run of 1,2 afterwards gives sum=3.
- Back-to-back runs: run A (250,10 -> sum=4, overflow=1), then run B (1,1) -> acc and overflow cleared at start, sum=2, overflow=0.
